// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit. The carry chain is cut into STAGES slices, with a register after each slice.
// Valid/ready flow control collapses bubbles. Outputs come straight from the last stage registers.

module pipelined_addsub_slice #(
  parameter int WIDTH = 9,
  parameter int LO    = 0,
  parameter int HI    = 9
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] yy_in,
  input  logic             c_in,
  output logic [WIDTH-1:0] r_out,
  output logic             c_out
);
  // Slice covers bits [LO,HI). LO==HI is an empty slice that only passes the carry through.
  localparam logic [WIDTH:0]   ONE    = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   MASK_F = ((ONE << HI) - ONE) ^ ((ONE << LO) - ONE);
  localparam logic [WIDTH-1:0] MASK   = MASK_F[WIDTH-1:0];

  logic [WIDTH:0] part;

  // The carry lands at bit HI of part, which is the only set bit outside the slice.
  always_comb begin
    part  = {1'b0, r_in & MASK} + {1'b0, yy_in & MASK} + ({{WIDTH{1'b0}}, c_in} << LO);
    r_out = (r_in & ~MASK) | (part[WIDTH-1:0] & MASK);
    c_out = |(part & ~{1'b0, MASK});
  end
endmodule

module pipelined_addsub #(
  parameter int WIDTH  = 9,
  parameter int STAGES = 3
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int SW = (WIDTH + STAGES - 1) / STAGES;

  // Index 0 holds the values entering stage 0. Index k+1 holds the registers of stage k.
  // r carries the finished low sum bits merged with the still-unused high bits of x.
  logic [STAGES:0][WIDTH-1:0]   r_a;
  logic [STAGES:0]              c_a, xm_a, ym_a, vld_pipe;
  logic [STAGES-1:0][WIDTH-1:0] yy_a;
  logic [STAGES-1:0]            adv;

  assign yy_a[0]     = y ^ {WIDTH{sub}};
  assign r_a[0]      = x;
  assign c_a[0]      = c_in ^ sub;
  assign xm_a[0]     = x[WIDTH-1];
  assign ym_a[0]     = yy_a[0][WIDTH-1];
  assign vld_pipe[0] = in_valid;

  // A stage may load when it is empty or when the stage after it is moving.
  always_comb begin
    logic go;
    adv = '0;
    go  = !vld_pipe[STAGES] || out_ready;
    adv[STAGES-1] = go;
    for (int k = STAGES - 2; k >= 0; k--) begin
      go     = !vld_pipe[k+1] || go;
      adv[k] = go;
    end
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = (k * SW < WIDTH) ? k * SW : WIDTH;
    localparam int HI = ((k + 1) * SW < WIDTH) ? (k + 1) * SW : WIDTH;

    logic [WIDTH-1:0] r_d, r_q;
    logic             c_d, c_q, xm_q, ym_q, v_q;

    pipelined_addsub_slice #(.WIDTH(WIDTH), .LO(LO), .HI(HI)) u_slice (
      .r_in  (r_a[k]),
      .yy_in (yy_a[k]),
      .c_in  (c_a[k]),
      .r_out (r_d),
      .c_out (c_d)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        v_q  <= 1'b0;
        r_q  <= '0;
        c_q  <= 1'b0;
        xm_q <= 1'b0;
        ym_q <= 1'b0;
      end else if (adv[k]) begin
        v_q  <= vld_pipe[k];
        r_q  <= r_d;
        c_q  <= c_d;
        xm_q <= xm_a[k];
        ym_q <= ym_a[k];
      end
    end

    assign r_a[k+1]      = r_q;
    assign c_a[k+1]      = c_q;
    assign xm_a[k+1]     = xm_q;
    assign ym_a[k+1]     = ym_q;
    assign vld_pipe[k+1] = v_q;

    // The last stage has no consumer for the inverted operand.
    if (k < STAGES - 1) begin : g_yy
      logic [WIDTH-1:0] yy_q;
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)    yy_q <= '0;
        else if (adv[k]) yy_q <= yy_a[k];
      end
      assign yy_a[k+1] = yy_q;
    end
  end

  assign s         = r_a[STAGES];
  assign c_out     = c_a[STAGES];
  assign out_valid = vld_pipe[STAGES];
  assign ovf       = (xm_a[STAGES] == ym_a[STAGES]) && (r_a[STAGES][WIDTH-1] != xm_a[STAGES]);
endmodule
